// File: rtl/mont_expo_sched.sv
// Round-robin scheduler sharing one mont_expo engine among NREQ requesters.
// Optional watchdog: define MEXP_SCHED_TIMEOUT_EN to bound the BUSY wait to TIMEOUT_CYCLES.
module mont_expo_sched #(
  parameter int WIDTH          = 192,
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_z,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [WIDTH-1:0]      eng_x,
  output logic [WIDTH-1:0]      eng_y,
  output logic                  eng_reset,
  output logic                  eng_start,
  input  logic [WIDTH-1:0]      eng_z,
  input  logic                  eng_done,
  output logic [2:0]            dbg_state
);
  // Handshake: req_valid[i] is a level held until the single-cycle req_ready[i]
  // pulse; every accepted request yields exactly one single-cycle rsp_valid[i].
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, BUSY = 3'd3, RESP = 3'd4} state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t            state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    gnt_id_q;
  logic              done_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [WIDTH-1:0]  rsp_z_q;
  logic              busy_q;
  logic [WIDTH-1:0]  eng_x_q;
  logic [WIDTH-1:0]  eng_y_q;
  logic              eng_reset_q;
  logic              eng_start_q;
  logic              pick_any_d;
  logic [IDW-1:0]    pick_id_d;
  logic              done_rise;

`ifdef MEXP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     to_cnt_q;
  logic              rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Scan downward so the lowest offset from rr_ptr_q is the last (winning) assignment.
  always_comb begin
    pick_any_d = 1'b0;
    pick_id_d  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        pick_any_d = 1'b1;
        pick_id_d  = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // Only a fresh rising edge of done counts; LOAD clears done_q so a stale level is ignored.
  assign done_rise = eng_done && !done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      done_q      <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      busy_q      <= 1'b0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      eng_reset_q <= 1'b1;
      eng_start_q <= 1'b0;
`ifdef MEXP_SCHED_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef MEXP_SCHED_TIMEOUT_EN
          rsp_err_q <= 1'b0;
`endif
          if (pick_any_d) begin
            state_q     <= LOAD;
            gnt_id_q    <= pick_id_d;
            eng_x_q     <= req_x[int'(pick_id_d)*WIDTH +: WIDTH];
            eng_y_q     <= req_y[int'(pick_id_d)*WIDTH +: WIDTH];
            req_ready_q <= ONE << pick_id_d;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          state_q     <= START;
          req_ready_q <= '0;
          rr_ptr_q    <= IDW'((int'(gnt_id_q) + 1) % NREQ);
          done_q      <= 1'b0;
          eng_reset_q <= 1'b0;
          eng_start_q <= 1'b1;
        end
        START: begin
          state_q     <= BUSY;
          eng_start_q <= 1'b0;
`ifdef MEXP_SCHED_TIMEOUT_EN
          to_cnt_q    <= '0;
`endif
        end
        BUSY: begin
          done_q <= eng_done;
          if (done_rise) begin
            state_q     <= RESP;
            rsp_z_q     <= eng_z;
            rsp_valid_q <= ONE << gnt_id_q;
            eng_reset_q <= 1'b1;
          end
`ifdef MEXP_SCHED_TIMEOUT_EN
          else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= RESP;
            rsp_z_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= ONE << gnt_id_q;
            eng_reset_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
`endif
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = busy_q;
  assign eng_x     = eng_x_q;
  assign eng_y     = eng_y_q;
  assign eng_reset = eng_reset_q;
  assign eng_start = eng_start_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mont_expo_sched.sv
// Bench for mont_expo_sched: XOR engine model, queue-based round-robin reference, per-scenario tasks.
module tb_mont_expo_sched;
  localparam int WIDTH  = 192;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int TO     = 50;
  localparam int LAT    = 22;  // LOAD cycle to RESP cycle with a 20-cycle engine
  localparam int TO_LAT = 52;  // LOAD, START, 50 BUSY cycles, RESP

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid = '0;
  logic [WIDTH-1:0]      rx [NREQ];
  logic [WIDTH-1:0]      ry [NREQ];
  logic [NREQ*WIDTH-1:0] req_x, req_y;
  logic [NREQ-1:0]       req_ready, rsp_valid;
  logic [WIDTH-1:0]      rsp_z, eng_x, eng_y;
  logic                  rsp_err, busy, eng_reset, eng_start;
  logic [2:0]            dbg_state;

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*WIDTH +: WIDTH] = rx[i];
      req_y[i*WIDTH +: WIDTH] = ry[i];
    end
  end

  // Engine model: z = x ^ y, done raised 20 cycles after the start cycle, held until eng_reset.
  logic [WIDTH-1:0] m_z = '0;
  logic             m_done = 1'b0;
  logic             m_act = 1'b0;
  int               m_cnt = 0;
  bit               m_never = 1'b0;

  always @(posedge clk) begin
    if (eng_reset) begin
      m_done <= 1'b0;
      m_act  <= 1'b0;
      m_cnt  <= 0;
    end else if (eng_start) begin
      m_act <= 1'b1;
      m_cnt <= 0;
    end else if (m_act && !m_never) begin
      if (m_cnt == 18) begin
        m_done <= 1'b1;
        m_z    <= eng_x ^ eng_y;
        m_act  <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  mont_expo_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .busy(busy), .eng_x(eng_x), .eng_y(eng_y), .eng_reset(eng_reset), .eng_start(eng_start),
    .eng_z(m_z), .eng_done(m_done), .dbg_state(dbg_state)
  );

  // Monitor: log every grant, start and response with its cycle number.
  int               cyc = 0;
  logic [NREQ-1:0]  gnt_q[$];
  int               gnt_cyc_q[$];
  logic             gnt_er_q[$];
  int               st_cyc_q[$];
  logic [NREQ-1:0]  rsp_v_q[$];
  logic [WIDTH-1:0] rsp_z_q[$];
  logic             rsp_e_q[$];
  int               rsp_cyc_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (req_ready != '0) begin
      gnt_q.push_back(req_ready);
      gnt_cyc_q.push_back(cyc);
      gnt_er_q.push_back(eng_reset);
    end
    if (eng_start) st_cyc_q.push_back(cyc);
    if (rsp_valid != '0) begin
      rsp_v_q.push_back(rsp_valid);
      rsp_z_q.push_back(rsp_z);
      rsp_e_q.push_back(rsp_err);
      rsp_cyc_q.push_back(cyc);
    end
  end

  // Reference: round-robin over the pending set, sticky requesters stay pending after a grant.
  int               errors = 0;
  int               checks = 0;
  int               m_ptr = 0;
  int               exp_ord[$];
  logic [WIDTH-1:0] exp_q[$];

  function automatic void rr_order(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] sticky, input int n);
    logic [NREQ-1:0] pend = mask;
    exp_ord.delete();
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        int g = (m_ptr + j) % NREQ;
        if (pend[g]) begin
          exp_ord.push_back(g);
          exp_q.push_back(rx[g] ^ ry[g]);
          m_ptr = (g + 1) % NREQ;
          if (!sticky[g]) pend[g] = 1'b0;
          break;
        end
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++)
      for (int w = 0; w < WIDTH/32; w++) begin
        rx[i][w*32 +: 32] = $urandom();
        ry[i][w*32 +: 32] = $urandom();
      end
  endtask

  // Driver: hold mask, drop each non-sticky bit on its ready, drop all after n grants.
  task automatic drive_ops(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] sticky, input int n,
                           output int g0, output int r0, output bit ok);
    int ng = 0;
    ok = 1'b0;
    g0 = gnt_q.size();
    r0 = rsp_v_q.size();
    req_valid = mask;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk); #1;
      if (req_ready != '0) begin
        ng++;
        req_valid = req_valid & ~(req_ready & ~sticky);
        if (ng >= n) req_valid = '0;
      end
      if (rsp_v_q.size() - r0 >= n && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) begin rx[i] = '0; ry[i] = '0; end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (eng_reset !== 1'b1) begin errors++; $display("FAIL reset_eng_reset: got %b expected 1", eng_reset); end
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b expected 0", eng_start); end
    checks++; if ({req_ready, rsp_valid} !== '0) begin errors++; $display("FAIL reset_handshake: got %b expected 0", {req_ready, rsp_valid}); end
    checks++; if ({rsp_z, eng_x, eng_y, rsp_err} !== '0) begin errors++; $display("FAIL reset_data: got nonzero expected 0"); end
    reset = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int g0, r0, s0;
    bit ok;
    rx[1] = 192'h6543210fedcba9876543210fedcba9876543210fedcba987;
    ry[1] = 192'hfedcba9876543210fedcba9876543210fedcba9876543210;
    rr_order(4'b0010, 4'b0000, 1);
    s0 = st_cyc_q.size();
    drive_ops(4'b0010, 4'b0000, 1, g0, r0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no response expected 1"); end
    checks++; if (gnt_q.size() - g0 != 1 || gnt_q[g0] !== 4'b0010) begin errors++; $display("FAIL single_ready: got %0d pulses expected one of 0010", gnt_q.size() - g0); end
    checks++; if (gnt_er_q[g0] !== 1'b1) begin errors++; $display("FAIL single_load_reset: got %b expected 1", gnt_er_q[g0]); end
    checks++; if (st_cyc_q.size() - s0 != 1 || st_cyc_q[s0] != gnt_cyc_q[g0] + 1) begin errors++; $display("FAIL single_start: got %0d starts expected 1 one cycle after LOAD", st_cyc_q.size() - s0); end
    checks++; if (rsp_v_q[r0] !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0010", rsp_v_q[r0]); end
    checks++; if (rsp_z_q[r0] !== exp_q[0]) begin errors++; $display("FAIL single_rsp_z: got %h expected %h", rsp_z_q[r0], exp_q[0]); end
    checks++; if (rsp_e_q[r0] !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b expected 0", rsp_e_q[r0]); end
    checks++; if (rsp_cyc_q[r0] - gnt_cyc_q[g0] != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", rsp_cyc_q[r0] - gnt_cyc_q[g0], LAT); end
  endtask

  task automatic test_all_four();
    int g0, r0;
    bit ok;
    do_reset();
    randomize_ops();
    rr_order(4'b1111, 4'b0000, 4);
    drive_ops(4'b1111, 4'b0000, 4, g0, r0, ok);
    checks++; if (!ok || gnt_q.size() - g0 != 4) begin errors++; $display("FAIL all4_count: got %0d grants expected 4", gnt_q.size() - g0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (gnt_q[g0+k] !== NREQ'(1 << exp_ord[k])) begin errors++; $display("FAIL all4_grant%0d: got %b expected %b", k, gnt_q[g0+k], NREQ'(1 << exp_ord[k])); end
      checks++; if (rsp_v_q[r0+k] !== NREQ'(1 << exp_ord[k]) || rsp_z_q[r0+k] !== exp_q[k]) begin errors++; $display("FAIL all4_rsp%0d: got %b/%h expected %b/%h", k, rsp_v_q[r0+k], rsp_z_q[r0+k], NREQ'(1 << exp_ord[k]), exp_q[k]); end
    end
  endtask

  task automatic test_sticky();
    int g0, r0;
    bit ok;
    randomize_ops();
    rr_order(4'b0001, 4'b0000, 1);
    drive_ops(4'b0001, 4'b0000, 1, g0, r0, ok);
    rr_order(4'b1101, 4'b0100, 4);
    drive_ops(4'b1101, 4'b0100, 4, g0, r0, ok);
    checks++; if (!ok || gnt_q.size() - g0 != 4) begin errors++; $display("FAIL sticky_count: got %0d grants expected 4", gnt_q.size() - g0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (gnt_q[g0+k] !== NREQ'(1 << exp_ord[k]) || rsp_v_q[r0+k] !== NREQ'(1 << exp_ord[k])) begin errors++; $display("FAIL sticky_grant%0d: got %b/%b expected %b", k, gnt_q[g0+k], rsp_v_q[r0+k], NREQ'(1 << exp_ord[k])); end
    end
  endtask

  task automatic test_back_to_back();
    int g0, r0;
    bit ok;
    randomize_ops();
    rr_order(4'b1000, 4'b1000, 3);
    drive_ops(4'b1000, 4'b1000, 3, g0, r0, ok);
    checks++; if (!ok || rsp_v_q.size() - r0 != 3) begin errors++; $display("FAIL b2b_count: got %0d responses expected 3", rsp_v_q.size() - r0); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rsp_cyc_q[r0+k] - gnt_cyc_q[g0+k] != LAT) begin errors++; $display("FAIL b2b_latency%0d: got %0d expected %0d", k, rsp_cyc_q[r0+k] - gnt_cyc_q[g0+k], LAT); end
      if (k > 0) begin
        checks++; if (gnt_cyc_q[g0+k] - rsp_cyc_q[r0+k-1] != 2) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 2", k, gnt_cyc_q[g0+k] - rsp_cyc_q[r0+k-1]); end
      end
    end
  endtask

  task automatic test_random();
    int g0, r0, n;
    bit ok;
    logic [NREQ-1:0] mask;
    for (int round = 0; round < 6; round++) begin
      randomize_ops();
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      n = $countones(mask);
      rr_order(mask, '0, n);
      drive_ops(mask, '0, n, g0, r0, ok);
      checks++; if (!ok || gnt_q.size() - g0 != n) begin errors++; $display("FAIL rand%0d_count: got %0d grants expected %0d", round, gnt_q.size() - g0, n); end
      for (int k = 0; k < n; k++) begin
        checks++; if (gnt_q[g0+k] !== NREQ'(1 << exp_ord[k]) || rsp_z_q[r0+k] !== exp_q[k] || rsp_e_q[r0+k] !== 1'b0) begin errors++; $display("FAIL rand%0d_op%0d: got %b/%h expected %b/%h", round, k, gnt_q[g0+k], rsp_z_q[r0+k], NREQ'(1 << exp_ord[k]), exp_q[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int g0, r0, n0;
    bit ok;
    randomize_ops();
    req_valid = 4'b0010;
    for (int t = 0; t < 100 && req_ready == '0; t++) @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    n0 = rsp_v_q.size();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || eng_reset !== 1'b1 || eng_start !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got busy=%b eng_reset=%b eng_start=%b expected 0 1 0", busy, eng_reset, eng_start); end
    repeat (30) @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    repeat (5) @(negedge clk);
    checks++; if (rsp_v_q.size() != n0) begin errors++; $display("FAIL midreset_no_rsp: got %0d responses expected 0", rsp_v_q.size() - n0); end
    rr_order(4'b0100, 4'b0000, 1);
    drive_ops(4'b0100, 4'b0000, 1, g0, r0, ok);
    checks++; if (!ok || gnt_q[g0] !== 4'b0100 || rsp_z_q[r0] !== exp_q[0]) begin errors++; $display("FAIL midreset_recover: got %b/%h expected 0100/%h", gnt_q[g0], rsp_z_q[r0], exp_q[0]); end
  endtask

`ifdef MEXP_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int g0, r0;
    bit ok;
    randomize_ops();
    m_never = 1'b1;
    rr_order(4'b0001, 4'b0000, 1);
    drive_ops(4'b0001, 4'b0000, 1, g0, r0, ok);
    m_never = 1'b0;
    checks++; if (!ok || rsp_v_q[r0] !== 4'b0001) begin errors++; $display("FAIL timeout_rsp: got %b expected 0001", rsp_v_q[r0]); end
    checks++; if (rsp_e_q[r0] !== 1'b1 || rsp_z_q[r0] !== '0) begin errors++; $display("FAIL timeout_err: got err=%b z=%h expected err=1 z=0", rsp_e_q[r0], rsp_z_q[r0]); end
    checks++; if (rsp_cyc_q[r0] - gnt_cyc_q[g0] != TO_LAT) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", rsp_cyc_q[r0] - gnt_cyc_q[g0], TO_LAT); end
  endtask
`endif

  initial begin
    fork
      begin
        #3000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "bench time limit");
      end
    join_none
    test_reset();
    test_single();
    test_all_four();
    test_sticky();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef MEXP_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_expo_sched.md
# mont_expo_sched

Round-robin scheduler that shares one `mont_expo` engine (192-bit operands `x`, `y`, result `z`, completion flag `done1`) among NREQ requesters. It accepts an operand pair from one requester at a time and sequences the engine's reset/start protocol. It detects completion and returns the result to the originating requester with a one-cycle response pulse. It sits between the crypto request fabric and the single `mont_expo` instance.

## Interface
- `WIDTH`, 192, operand/result width
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester index width, ≥ clog2(NREQ)
- `TIMEOUT_CYCLES`, 1000000, watchdog limit; used only with `MEXP_SCHED_TIMEOUT_EN`
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request; level, held until `req_ready[i]`
- `req_x`  in  NREQ*WIDTH  flattened operand x; slice i = bits [i*WIDTH +: WIDTH]
- `req_y`  in  NREQ*WIDTH  flattened operand y, same slicing
- `req_ready`  out  NREQ  one-hot accept pulse, 1 cycle
- `rsp_valid`  out  NREQ  one-hot result pulse, 1 cycle
- `rsp_z`  out  WIDTH  result; valid while any `rsp_valid` is high, held until the next response
- `rsp_err`  out  1  high with `rsp_valid` when the operation timed out (0 when the feature is absent)
- `busy`  out  1  high in every state except IDLE
- `eng_x`, `eng_y`  out  WIDTH  engine operands, registered, stable from LOAD until the next LOAD
- `eng_reset`  out  1  engine reset, active-high
- `eng_start`  out  1  engine start
- `eng_z`  in  WIDTH  engine result
- `eng_done`  in  1  engine `done1`

## Operation
- FSM states: IDLE, LOAD, START, BUSY, RESP.
- IDLE: if any `req_valid` is high, grant the first set bit at or after `rr_ptr`, wrapping modulo NREQ. Capture that requester's x/y into `eng_x`/`eng_y`, store the grant index in `gnt_id`, and go to LOAD. With no request, stay in IDLE.
- LOAD (1 cycle): `req_ready[gnt_id]`=1, `eng_reset`=1, `eng_start`=0. Set `rr_ptr` = (`gnt_id`+1) mod NREQ. Clear `done_q`. Go to START.
- START (1 cycle): `eng_reset`=0, `eng_start`=1. Go to BUSY.
- BUSY: `eng_reset`=0, `eng_start`=0. Register `done_q` <= `eng_done`. Completion is `eng_done`=1 && `done_q`=0 (rising edge). On completion, latch `rsp_z` <= `eng_z` and go to RESP. A `done1` level left over from the previous operation is ignored because LOAD clears `done_q` and resets the engine.
- RESP (1 cycle): `rsp_valid[gnt_id]`=1. Go to IDLE.
- `eng_reset` is 1 in IDLE, LOAD and RESP, so the engine is held reset whenever it is unused.
- Arbitration boundaries: a requester that drops `req_valid` before its `req_ready` is never granted. Requests arriving in any non-IDLE state wait. Simultaneous requests resolve strictly by round-robin, so no requester is granted twice while another is pending.
- `req_valid[i]` may stay high after its `req_ready[i]`. It is then treated as a new request at the requester's next round-robin turn.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `gnt_id`=0, `done_q`=0, `req_ready`=0, `rsp_valid`=0, `rsp_z`=0, `rsp_err`=0, `busy`=0, `eng_x`=0, `eng_y`=0, `eng_reset`=1, `eng_start`=0.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.
- Request seen at edge k (in IDLE): LOAD during cycle k+1, START during cycle k+2.
- Engine done rising sampled at edge m: RESP during cycle m+1, IDLE from cycle m+2.
- Minimum spacing is one IDLE cycle between RESP and the next LOAD.
- If `reset` asserts mid-operation, all registers return to reset values immediately, `eng_reset`=1, and no response is issued for the aborted request.

## Configuration
- `MEXP_SCHED_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without completion, go to RESP with `rsp_err`=1 and `rsp_z`=0.
  - `rsp_err` clears in IDLE.
- `MEXP_SCHED_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely and `rsp_err` is tied to 0.

## Test plan
- Engine model for the bench: returns `z` = x XOR y, raising `eng_done` 20 cycles after `eng_start`. `done1` stays high until `eng_reset`.
- Single request: req 1, x=`6543210fedcba9876543210fedcba9876543210fedcba987`, y=`fedcba9876543210fedcba9876543210fedcba9876543210` -> `req_ready`=4'b0010 for 1 cycle. The engine sees `eng_reset`=1, then `eng_start`=1. `rsp_valid`=4'b0010 with `rsp_z`=x^y.
- All four requesters assert simultaneously after reset -> grant order 0,1,2,3. Each `rsp_valid` matches its own x^y; no requester is granted twice.
- Requester 2 holds `req_valid` continuously while 0 and 3 also request (`rr_ptr`=1) -> grant order 2,3,0,2.
- Stale done: the model keeps `done1` high after completion -> the next operation's RESP occurs only after the new rising edge (≥20 cycles after START), never early.
- Reset (`reset`=0) asserted mid-BUSY -> `busy`=0 and `eng_reset`=1 at once, no `rsp_valid`. After release, a new request completes normally.
- With `MEXP_SCHED_TIMEOUT_EN` and TIMEOUT_CYCLES=50, the model never raises done -> RESP 50 BUSY cycles after START, with `rsp_err`=1 and `rsp_z`=0.
